neopixel_sequencer: RTL and testbench

- Autonomous frame sequencer that drives the pixel-buffer control interface of the neopixel driver (write strobe, address and data) from a single clock.
- Once per frame period it:
  - writes a "chaser" pattern (one lit pixel, colour rotating R→G→B) into the pixel buffer;
  - issues a refresh command;
  - waits for the driver to finish before advancing.
- It replaces a hand-driven control source and sits between the top level and the neopixel driver.

---
 rtl/neopixel_pkg.sv | 52 +++++
 rtl/neopixel_frame_timer.sv | 27 ++
 rtl/neopixel_sequencer.sv | 144 ++++++++++++++
 tb/tb_neopixel_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// rtl/neopixel_pkg.sv - shared types, constants and pixel word helpers for the neopixel sequencer
package neopixel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GO,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_ADVANCE
    } state_t;

    typedef enum logic [1:0] {
        COL_RED,
        COL_GREEN,
        COL_BLUE
    } colour_t;

    // Driver control register; writing bit0=1 kicks off a refresh.
    localparam logic [31:0] GO_ADDR_DEFAULT = 32'h0000_0100;

    // Cycles to wait for the driver to drop ctrl_ready before assuming an instant refresh.
    localparam int START_TIMEOUT = 16;

    // Pixel buffer word layout: {8'h00, G, R, B}.
    function automatic logic [31:0] pixel_word(input logic [7:0] g, input logic [7:0] r,
                                               input logic [7:0] b);
        return {8'h00, g, r, b};
    endfunction

    function automatic logic [31:0] colour_word(input colour_t c, input logic [7:0] level);
        logic [31:0] w;
        case (c)
            COL_RED:   w = pixel_word(8'h00, level, 8'h00);
            COL_GREEN: w = pixel_word(level, 8'h00, 8'h00);
            COL_BLUE:  w = pixel_word(8'h00, 8'h00, level);
            default:   w = 32'h0;
        endcase
        return w;
    endfunction

    function automatic colour_t next_colour(input colour_t c);
        colour_t n;
        case (c)
            COL_RED:   n = COL_GREEN;
            COL_GREEN: n = COL_BLUE;
            default:   n = COL_RED;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/neopixel_frame_timer.sv
// rtl/neopixel_frame_timer.sv - free-running frame period counter with one-cycle tick
module neopixel_frame_timer
    import neopixel_pkg::*;
#(
    parameter logic [31:0] C_RATE = 32'd33000000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    logic [31:0] count;

    // Count 0..C_RATE-1 and wrap; never gated so the frame cadence stays fixed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 32'd0;
        end else if (count == C_RATE - 32'd1) begin
            count <= 32'd0;
        end else begin
            count <= count + 32'd1;
        end
    end

    assign tick = (count == C_RATE - 32'd1);

endmodule

// File: rtl/neopixel_sequencer.sv
// rtl/neopixel_sequencer.sv - autonomous chaser-pattern frame sequencer for the neopixel driver
module neopixel_sequencer
    import neopixel_pkg::*;
#(
    parameter int          C_PIXELS  = 12,
    parameter logic [31:0] C_RATE    = 32'd33000000,
    parameter logic [7:0]  C_LEVEL   = 8'h40,
    parameter logic [31:0] C_GO_ADDR = GO_ADDR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        ctrl_ready,
    output logic        write_readf,
    output logic [31:0] address,
    output logic [31:0] write_data,
    output logic        busy,
    output logic        overrun,
    output logic [7:0]  position
);

    localparam logic [7:0] LAST_INDEX = 8'(C_PIXELS - 1);
    localparam logic [3:0] WAIT_LAST  = 4'(START_TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic        tick;
    logic [7:0]  index;
    logic [3:0]  wait_cnt;
    colour_t     colour;
    logic [31:0] addr_hold;
    logic [31:0] data_hold;

    neopixel_frame_timer #(
        .C_RATE(C_RATE)
    ) u_timer (
        .clock(clock),
        .reset(reset),
        .tick (tick)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and bus outputs; strobe is decoded from state so reset kills it immediately.
    always_comb begin
        state_next  = state;
        write_readf = 1'b0;
        address     = addr_hold;
        write_data  = data_hold;
        overrun     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick && enable) begin
                    if (ctrl_ready) begin
                        state_next = ST_LOAD;
                    end else begin
                        overrun = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                write_readf = 1'b1;
                address     = {24'h0, index};
                write_data  = (index == position) ? colour_word(colour, C_LEVEL) : 32'h0;
                if (index == LAST_INDEX) begin
                    state_next = ST_GO;
                end
            end
            ST_GO: begin
                write_readf = 1'b1;
                address     = C_GO_ADDR;
                write_data  = 32'h1;
                state_next  = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (!ctrl_ready || wait_cnt == WAIT_LAST) begin
                    state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (ctrl_ready) begin
                    state_next = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // Ticks while a frame is in flight are discarded, never queued.
        if (tick && state != ST_IDLE) begin
            overrun = 1'b1;
        end
    end

    assign busy = (state != ST_IDLE);

    // Frame datapath: write index, start-timeout counter, chaser position and colour.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            index    <= 8'd0;
            wait_cnt <= 4'd0;
            position <= 8'd0;
            colour   <= COL_RED;
        end else begin
            case (state)
                ST_IDLE:       index    <= 8'd0;
                ST_LOAD:       index    <= index + 8'd1;
                ST_GO:         wait_cnt <= 4'd0;
                ST_WAIT_START: wait_cnt <= wait_cnt + 4'd1;
                ST_ADVANCE: begin
                    if (position == LAST_INDEX) begin
                        position <= 8'd0;
                        colour   <= next_colour(colour);
                    end else begin
                        position <= position + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Remember the last word driven so address/data hold steady between frames.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_hold <= 32'h0;
            data_hold <= 32'h0;
        end else if (write_readf) begin
            addr_hold <= address;
            data_hold <= write_data;
        end
    end

endmodule

// File: tb/tb_neopixel_sequencer.sv
// tb/tb_neopixel_sequencer.sv - directed table-driven bench for neopixel_sequencer
module tb_neopixel_sequencer;

    localparam logic [31:0] RED   = 32'h0000_4000;
    localparam logic [31:0] GREEN = 32'h0040_0000;
    localparam logic [31:0] BLUE  = 32'h0000_0040;
    localparam logic [31:0] GOA   = 32'h0000_0100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        ctrl_ready = 1'b1;
    logic        write_readf;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        busy;
    logic        overrun;
    logic [7:0]  position;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_wr = 0;
    int n_ovr = 0;
    int drop_len = 10;

    neopixel_sequencer #(
        .C_PIXELS (4),
        .C_RATE   (32'd40),
        .C_LEVEL  (8'h40),
        .C_GO_ADDR(GOA)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .ctrl_ready (ctrl_ready),
        .write_readf(write_readf),
        .address    (address),
        .write_data (write_data),
        .busy       (busy),
        .overrun    (overrun),
        .position   (position)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial forever begin
        @(negedge clock);
        if (write_readf) n_wr++;
        if (overrun) n_ovr++;
    end

    // Driver model: ctrl_ready drops 2 cycles after GO for drop_len cycles (0 = never drops).
    initial forever begin
        @(negedge clock);
        if (!reset && write_readf && address == GOA && drop_len > 0) begin
            repeat (2) @(negedge clock);
            ctrl_ready = 1'b0;
            repeat (drop_len) @(negedge clock);
            ctrl_ready = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic run_frame(input int lit, input logic [31:0] word, input bit kill,
                             output int first_c, output int go_c, output int done_c);
        int n;
        n = 0;
        first_c = 0;
        go_c = 0;
        done_c = 0;
        while (!write_readf && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("frame_start", 32'(write_readf), 32'd1);
        if (!write_readf) return;
        first_c = cyc;
        for (int p = 0; p < 4; p++) begin
            check("load_strobe", 32'(write_readf), 32'd1);
            check("load_addr", address, 32'(p));
            check("load_data", write_data, (p == lit) ? word : 32'h0);
            if (p == 0 && kill) enable = 1'b0;
            @(negedge clock);
        end
        check("go_strobe", 32'(write_readf), 32'd1);
        check("go_addr", address, GOA);
        check("go_data", write_data, 32'h1);
        go_c = cyc;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("frame_done", 32'(busy), 32'd0);
        done_c = cyc;
    endtask

    typedef struct {
        int          lit;
        logic [31:0] word;
        int          mode;     // 0 normal, 1 long refresh, 2 no refresh, 3 enable drop in LOAD
        logic [7:0]  pos_after;
    } frame_vec_t;

    frame_vec_t vecs[13];

    initial begin
        int base, fc, gc, dc, wr0, ov0;
        logic [7:0] pos0;

        vecs[0]  = '{0, RED,   0, 8'd1};
        vecs[1]  = '{1, RED,   0, 8'd2};
        vecs[2]  = '{2, RED,   0, 8'd3};
        vecs[3]  = '{3, RED,   0, 8'd0};
        vecs[4]  = '{0, GREEN, 0, 8'd1};
        vecs[5]  = '{1, GREEN, 0, 8'd2};
        vecs[6]  = '{2, GREEN, 0, 8'd3};
        vecs[7]  = '{3, GREEN, 0, 8'd0};
        vecs[8]  = '{0, BLUE,  0, 8'd1};
        vecs[9]  = '{1, BLUE,  1, 8'd2};
        vecs[10] = '{2, BLUE,  0, 8'd3};
        vecs[11] = '{3, BLUE,  2, 8'd0};
        vecs[12] = '{0, RED,   3, 8'd1};

        repeat (3) @(negedge clock);
        check("rst_write_readf", 32'(write_readf), 32'd0);
        check("rst_address", address, 32'h0);
        check("rst_write_data", write_data, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_position", 32'(position), 32'd0);
        reset = 1'b0;
        enable = 1'b1;
        base = cyc;

        for (int i = 0; i < 13; i++) begin
            drop_len = (vecs[i].mode == 1) ? 50 : (vecs[i].mode == 2) ? 0 : 10;
            wr0 = n_wr;
            ov0 = n_ovr;
            run_frame(vecs[i].lit, vecs[i].word, vecs[i].mode == 3, fc, gc, dc);
            check("pos_after", 32'(position), 32'(vecs[i].pos_after));
            check("frame_writes", 32'(n_wr - wr0), 32'd5);
            check("frame_overruns", 32'(n_ovr - ov0), (vecs[i].mode == 1) ? 32'd1 : 32'd0);
            if (i == 0) begin
                check("first_write_cycle", 32'(fc - base), 32'd40);
                check("first_go_cycle", 32'(gc - base), 32'd44);
            end
            if (vecs[i].mode == 2) begin
                check("timeout_go_to_idle", 32'(dc - gc), 32'd19);
            end
        end
        drop_len = 10;

        // enable stays low for three tick periods: nothing written, position frozen.
        wr0 = n_wr;
        ov0 = n_ovr;
        pos0 = position;
        repeat (120) @(negedge clock);
        check("disabled_writes", 32'(n_wr - wr0), 32'd0);
        check("disabled_overruns", 32'(n_ovr - ov0), 32'd0);
        check("disabled_position", 32'(position), 32'(pos0));

        // Reset during LOAD at index 2.
        enable = 1'b1;
        fc = 0;
        while (!write_readf && fc < 100) begin
            @(negedge clock);
            fc++;
        end
        check("rst_frame_start", 32'(write_readf), 32'd1);
        repeat (2) @(negedge clock);
        check("rst_mid_addr", address, 32'd2);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_strobe", 32'(write_readf), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        base = cyc;
        check("rst_mid_position", 32'(position), 32'd0);
        run_frame(0, RED, 1'b0, fc, gc, dc);
        check("post_rst_first_write", 32'(fc - base), 32'd40);
        check("post_rst_go", 32'(gc - base), 32'd44);
        check("post_rst_position", 32'(position), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
